// File: rtl/apb_requester.sv
// apb_requester: bridges a valid/ready command port onto an APB bus, one transfer in flight,
// with address-decode and ready-timeout errors folded into the response.
module apb_requester #(
   parameter int AddrWidth   = 32,
   parameter int DataWidth   = 32,
   parameter int NumSub      = 4,
   parameter int SubAddrBits = 8,
   parameter int Timeout     = 16
) (
   input  logic                 clk,
   input  logic                 nReset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [AddrWidth-1:0] cmd_addr,
   input  logic [DataWidth-1:0] cmd_wData,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DataWidth-1:0] rsp_rData,
   output logic                 rsp_err,
   output logic [NumSub-1:0]    sel,
   output logic                 enable,
   output logic                 write,
   output logic [AddrWidth-1:0] addr,
   output logic [DataWidth-1:0] wData,
   input  logic [DataWidth-1:0] rData,
   input  logic                 ready,
   input  logic                 subErr
);
   localparam int IdxW = (NumSub > 1) ? $clog2(NumSub) : 1;
   localparam int CntW = $clog2(Timeout + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t          state, state_d;
   logic [CntW-1:0] count;
   logic [IdxW-1:0] idx;
   logic            hit, timed_out, unused_addr;

   assign idx         = cmd_addr[SubAddrBits +: IdxW];
   assign hit         = int'(idx) < NumSub;
   assign timed_out   = count == CntW'(Timeout - 1);
   assign cmd_ready   = state == IDLE;
   assign unused_addr = ^cmd_addr;

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = cmd_valid ? (hit ? SETUP : RESP) : IDLE;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = (ready || timed_out) ? RESP : ACCESS;
         default: state_d = rsp_ready ? IDLE : RESP;
      endcase
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) state <= IDLE;
      else         state <= state_d;
   end

   // Undecodable addresses skip the bus entirely and go straight to an error response.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         count     <= '0;
         sel       <= '0;
         enable    <= 1'b0;
         write     <= 1'b0;
         addr      <= '0;
         wData     <= '0;
         rsp_valid <= 1'b0;
         rsp_rData <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               write     <= cmd_write;
               addr      <= AddrWidth'(cmd_addr[SubAddrBits-1:0]);
               wData     <= cmd_wData;
               sel       <= hit ? NumSub'(1) << idx : '0;
               rsp_valid <= !hit;
               rsp_err   <= !hit;
               rsp_rData <= '0;
            end
            SETUP: enable <= 1'b1;
            ACCESS: if (ready || timed_out) begin
               sel       <= '0;
               enable    <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_err   <= ready ? subErr : 1'b1;
               rsp_rData <= (ready && !write) ? rData : '0;
               count     <= '0;
            end else begin
               count <= count + 1'b1;
            end
            default: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rData <= '0;
               count     <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed and randomized checks of apb_requester (NumSub=3, Timeout=16)
// against a latency/response model derived from the transfer rules.
module tb_apb_requester;
   logic        clk = 1'b0;
   logic        nReset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wData;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rData;
   logic [2:0]  sel;
   logic        enable, write;
   logic [31:0] addr, wData, rData;
   logic        ready, subErr;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      int          lat;
      int          setup_cyc;
      int          acc;
      logic [2:0]  sel;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
      int          viol;
      bit          idle_after;
   } obs_t;

   apb_requester #(.AddrWidth(32), .DataWidth(32), .NumSub(3), .SubAddrBits(8), .Timeout(16)) dut (
      .clk(clk), .nReset(nReset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wData(cmd_wData),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rData(rsp_rData), .rsp_err(rsp_err),
      .sel(sel), .enable(enable), .write(write), .addr(addr), .wData(wData),
      .rData(rData), .ready(ready), .subErr(subErr)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Expected transfer outcome: index>=3 errors one cycle after accept; otherwise
   // SETUP is one cycle and ACCESS lasts until ready or 16 cycles.
   function automatic void model(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                 input int wait_n, input logic serr, input logic [31:0] rdv,
                                 output obs_t e);
      int idx = int'(a[9:8]);
      int acc_cycles;
      e = '{default: 0};
      if (idx >= 3) begin
         e.lat = 1;
         e.err = 1'b1;
         e.idle_after = 1;
         return;
      end
      acc_cycles  = (wait_n + 1 < 16) ? wait_n + 1 : 16;
      e.setup_cyc = 1;
      e.acc       = acc_cycles;
      e.lat       = 2 + acc_cycles;
      e.sel       = 3'(1 << idx);
      e.addr      = {24'h0, a[7:0]};
      e.wr        = wr;
      e.wd        = d;
      e.err       = (wait_n >= 16) ? 1'b1 : serr;
      e.rd        = (wait_n < 16 && !wr) ? rdv : 32'h0;
      e.idle_after = 1;
   endfunction

   // Drives one command and plays the subordinate; returns what was observed.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input int wait_n,
                       input logic serr, input logic [31:0] rdv, input int hold, output obs_t o);
      int cyc = 0;
      int hcnt = 0;
      bit done = 0;
      o = '{default: 0};
      o.lat = -1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wData = d; rsp_ready = 1'b0;
      if (cmd_ready !== 1'b1) o.viol++;
      @(posedge clk);
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (o.lat < 0) begin
            cmd_valid = 1'b0;
            cmd_addr  = $urandom;
         end
         if (cmd_ready !== 1'b0) o.viol++;
         if ($countones(sel) > 1 || (enable && sel == 3'b0)) o.viol++;
         if (sel != 3'b0 && o.sel == 3'b0) begin
            o.sel = sel; o.addr = addr; o.wr = write; o.wd = wData; o.setup_cyc = cyc;
            if (enable !== 1'b0) o.viol++;
         end else if (sel != 3'b0 && (sel !== o.sel || addr !== o.addr || write !== o.wr || wData !== o.wd))
            o.viol++;
         ready = 1'b0; subErr = 1'b0; rData = $urandom;
         if (enable) begin
            o.acc++;
            if (o.acc > wait_n) begin
               ready = 1'b1; subErr = serr; rData = rdv;
            end
         end
         if (rsp_valid) begin
            if (o.lat < 0) begin
               o.lat = cyc; o.rd = rsp_rData; o.err = rsp_err;
            end else if (rsp_rData !== o.rd || rsp_err !== o.err) o.viol++;
            if (sel != 3'b0 || enable) o.viol++;
            cmd_valid = 1'b1; cmd_write = ~wr; cmd_addr = 32'h0000_0011;
            rsp_ready = (hcnt >= hold);
            hcnt++;
            if (rsp_ready) done = 1;
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0; rsp_ready = 1'b0; ready = 1'b0; subErr = 1'b0;
      o.idle_after = (cmd_ready === 1'b1 && rsp_valid === 1'b0 && sel === 3'b0 && enable === 1'b0);
   endtask

   task automatic test_reset;
      nReset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wData = '0;
      rsp_ready = 1'b0; rData = '0; ready = 1'b0; subErr = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({sel, enable, write, rsp_valid, rsp_err} !== 7'b0) begin n_bad++;
         $display("FAIL reset_ctrl: got %b want 0", {sel, enable, write, rsp_valid, rsp_err}); end
      n_cmp++; if ({addr, wData, rsp_rData} !== 96'b0) begin n_bad++;
         $display("FAIL reset_data: got %h %h %h want 0", addr, wData, rsp_rData); end
      nReset = 1'b1;
      @(negedge clk);
      n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_write_basic;
      obs_t o;
      xfer(1'b1, {22'h0, 2'd1, 8'h00}, 32'h0000_00A5, 0, 1'b0, 32'hDEAD_BEEF, 0, o);
      n_cmp++; if (o.setup_cyc !== 1) begin n_bad++; $display("FAIL wr_setup_cyc: got %0d want 1", o.setup_cyc); end
      n_cmp++; if (o.sel !== 3'b010) begin n_bad++; $display("FAIL wr_sel: got %b want 010", o.sel); end
      n_cmp++; if (o.addr !== 32'h0) begin n_bad++; $display("FAIL wr_addr: got %h want 0", o.addr); end
      n_cmp++; if (o.wr !== 1'b1 || o.wd !== 32'hA5) begin n_bad++;
         $display("FAIL wr_bus: got write=%b wData=%h want 1 a5", o.wr, o.wd); end
      n_cmp++; if (o.lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", o.lat); end
      n_cmp++; if (o.err !== 1'b0 || o.rd !== 32'h0) begin n_bad++;
         $display("FAIL wr_rsp: got err=%b rData=%h want 0 0", o.err, o.rd); end
      n_cmp++; if (o.viol !== 0 || !o.idle_after) begin n_bad++;
         $display("FAIL wr_protocol: got viol=%0d idle=%0d want 0 1", o.viol, o.idle_after); end
   endtask

   task automatic test_read_wait;
      obs_t o;
      xfer(1'b0, {22'h0, 2'd1, 8'h02}, 32'h0, 3, 1'b0, 32'h0000_1234, 0, o);
      n_cmp++; if (o.acc !== 4) begin n_bad++; $display("FAIL rd_access_len: got %0d want 4", o.acc); end
      n_cmp++; if (o.addr !== 32'h2 || o.wr !== 1'b0) begin n_bad++;
         $display("FAIL rd_bus: got addr=%h write=%b want 2 0", o.addr, o.wr); end
      n_cmp++; if (o.rd !== 32'h1234 || o.err !== 1'b0) begin n_bad++;
         $display("FAIL rd_data: got %h err=%b want 1234 0", o.rd, o.err); end
      n_cmp++; if (o.lat !== 6 || o.viol !== 0) begin n_bad++;
         $display("FAIL rd_timing: got lat=%0d viol=%0d want 6 0", o.lat, o.viol); end
   endtask

   task automatic test_suberr;
      obs_t o;
      xfer(1'b0, {22'h0, 2'd0, 8'h40}, 32'h0, 1, 1'b1, 32'h5555_0000, 0, o);
      n_cmp++; if (o.err !== 1'b1 || o.lat !== 4) begin n_bad++;
         $display("FAIL suberr_rsp: got err=%b lat=%0d want 1 4", o.err, o.lat); end
      n_cmp++; if (!o.idle_after || o.viol !== 0) begin n_bad++;
         $display("FAIL suberr_idle: got idle=%0d viol=%0d want 1 0", o.idle_after, o.viol); end
   endtask

   task automatic test_timeout;
      obs_t o;
      xfer(1'b0, {22'h0, 2'd2, 8'h10}, 32'h0, 20, 1'b0, 32'hFFFF_FFFF, 0, o);
      n_cmp++; if (o.acc !== 16 || o.lat !== 18) begin n_bad++;
         $display("FAIL timeout_len: got acc=%0d lat=%0d want 16 18", o.acc, o.lat); end
      n_cmp++; if (o.err !== 1'b1 || o.rd !== 32'h0) begin n_bad++;
         $display("FAIL timeout_rsp: got err=%b rData=%h want 1 0", o.err, o.rd); end
      n_cmp++; if (o.viol !== 0 || !o.idle_after) begin n_bad++;
         $display("FAIL timeout_drop: got viol=%0d idle=%0d want 0 1", o.viol, o.idle_after); end
   endtask

   task automatic test_rsp_hold;
      obs_t o;
      xfer(1'b0, {22'h0, 2'd2, 8'h7C}, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 5, o);
      n_cmp++; if (o.rd !== 32'hCAFE_F00D || o.err !== 1'b0) begin n_bad++;
         $display("FAIL hold_rsp: got %h err=%b want cafef00d 0", o.rd, o.err); end
      n_cmp++; if (o.viol !== 0 || !o.idle_after) begin n_bad++;
         $display("FAIL hold_stable: got viol=%0d idle=%0d want 0 1", o.viol, o.idle_after); end
   endtask

   task automatic test_decode_err;
      obs_t o;
      xfer(1'b1, {22'h0, 2'd3, 8'h08}, 32'h1111_2222, 0, 1'b0, 32'h0, 1, o);
      n_cmp++; if (o.lat !== 1 || o.acc !== 0) begin n_bad++;
         $display("FAIL dec_latency: got lat=%0d acc=%0d want 1 0", o.lat, o.acc); end
      n_cmp++; if (o.sel !== 3'b0) begin n_bad++; $display("FAIL dec_sel: got %b want 000", o.sel); end
      n_cmp++; if (o.err !== 1'b1 || o.rd !== 32'h0 || !o.idle_after) begin n_bad++;
         $display("FAIL dec_rsp: got err=%b rData=%h idle=%0d want 1 0 1", o.err, o.rd, o.idle_after); end
   endtask

   task automatic test_random;
      obs_t o, e;
      logic [21:0] up;
      logic [1:0]  idx;
      logic [7:0]  off;
      logic [31:0] a, d, rdv;
      logic        wr, serr;
      int          wait_n, r;
      for (int i = 0; i < 40; i++) begin
         up = 22'($urandom); idx = 2'($urandom_range(0, 3)); off = 8'($urandom);
         a = {up, idx, off}; d = $urandom; rdv = $urandom;
         wr = 1'($urandom_range(0, 1)); serr = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 9);
         wait_n = (r == 9) ? 16 + $urandom_range(0, 3) : r % 4;
         model(wr, a, d, wait_n, serr, rdv, e);
         xfer(wr, a, d, wait_n, serr, rdv, $urandom_range(0, 2), o);
         n_cmp++;
         if (o.lat !== e.lat || o.setup_cyc !== e.setup_cyc || o.acc !== e.acc || o.sel !== e.sel ||
             o.addr !== e.addr || o.wr !== e.wr || o.wd !== e.wd || o.rd !== e.rd || o.err !== e.err ||
             o.viol !== 0 || o.idle_after !== e.idle_after) begin
            n_bad++;
            $display("FAIL rand_%0d: got lat=%0d su=%0d acc=%0d sel=%b addr=%h wr=%b wd=%h rd=%h err=%b viol=%0d idle=%0d want lat=%0d su=%0d acc=%0d sel=%b addr=%h wr=%b wd=%h rd=%h err=%b viol=0 idle=1",
                     i, o.lat, o.setup_cyc, o.acc, o.sel, o.addr, o.wr, o.wd, o.rd, o.err, o.viol, o.idle_after,
                     e.lat, e.setup_cyc, e.acc, e.sel, e.addr, e.wr, e.wd, e.rd, e.err);
         end
      end
   endtask

   task automatic test_back_to_back;
      int n_acc = 0;
      int n_rsp = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = {22'h0, 2'd0, 8'h04}; cmd_wData = 32'h77;
      rsp_ready = 1'b1; ready = 1'b1; subErr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         n_acc += int'(cmd_ready);
         n_rsp += int'(rsp_valid);
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0; ready = 1'b0;
      n_cmp++; if (n_acc !== 5 || n_rsp !== 5) begin n_bad++;
         $display("FAIL b2b_rate: got accepts=%0d rsps=%0d in 20 cycles want 5 5", n_acc, n_rsp); end
      n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++;
         $display("FAIL b2b_drain: got cmd_ready=%b rsp_valid=%b want 1 0", cmd_ready, rsp_valid); end
   endtask

   task automatic test_reset_mid;
      int n_rsp = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = {22'h3, 2'd2, 8'h24}; cmd_wData = 32'h9ABC_DEF0;
      rsp_ready = 1'b1; ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (enable !== 1'b1 || sel !== 3'b100) begin n_bad++;
         $display("FAIL mid_access: got enable=%b sel=%b want 1 100", enable, sel); end
      @(negedge clk);
      #2 nReset = 1'b0;
      #1;
      n_cmp++; if ({sel, enable, write, rsp_valid, rsp_err} !== 7'b0 || {addr, wData, rsp_rData} !== 96'b0) begin
         n_bad++;
         $display("FAIL mid_reset_outputs: got sel=%b en=%b wr=%b rv=%b re=%b addr=%h wd=%h rd=%h want all 0",
                  sel, enable, write, rsp_valid, rsp_err, addr, wData, rsp_rData);
      end
      @(negedge clk);
      nReset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_rsp += int'(rsp_valid) + int'(sel != 3'b0);
      end
      rsp_ready = 1'b0;
      n_cmp++; if (n_rsp !== 0 || cmd_ready !== 1'b1) begin n_bad++;
         $display("FAIL mid_no_rsp: got activity=%0d cmd_ready=%b want 0 1", n_rsp, cmd_ready); end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_wait();
      test_suberr();
      test_timeout();
      test_rsp_hold();
      test_decode_err();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
